eq_serial_acc: RTL and testbench

- Bit-serial word-equality accumulator.
- Sits directly downstream of the 1-bit equality comparator; consumes its per-bit eq result, one bit per qualified cycle.
- After N qualified bits, reports whether every bit pair of the N-bit word matched.
- Raises a one-cycle completion pulse; the match result is held for the consumer.

---
 rtl/eq_pkg.sv | 15 +
 rtl/eq_serial_acc_bit_counter.sv | 34 +++
 rtl/eq_serial_acc.sv | 121 ++++++++++++
 tb/tb_eq_serial_acc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the bit-serial word-equality accumulator:
// FSM state encoding and bit-counter width derivation.
package eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/eq_serial_acc_bit_counter.sv
// Purpose: mod-N bit counter with synchronous clear and enable; o_last flags count == N-1.
// Latency: count updates on the edge after i_en; o_last is combinational from the count.
// Backpressure: none; deasserting i_en holds the count.
module bit_counter
    import eq_pkg::*;
#(
    parameter int N = 8,
    localparam int CNT_W = cnt_w(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    assign o_last  = (r_count == CNT_W'(N - 1));
    assign o_count = r_count;

    // Wrap is explicit at N-1 so power-of-two N never relies on natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/eq_serial_acc.sv
// Purpose: AND-accumulates N serial eq bits into a held match result; optional
// first-mismatch index via EQ_SERIAL_MISMATCH_IDX_EN.
// Latency: done_tick one cycle after the N-th qualified bit. Backpressure: bit_valid=0 stalls.
module eq_serial_acc
    import eq_pkg::*;
#(
    parameter int N = 8,
    localparam int CNT_W = cnt_w(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             eq_bit,
    output logic             busy,
    output logic             done_tick,
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
    output logic [CNT_W-1:0] mismatch_idx,
`endif
    output logic             match
);

    state_t           r_state;
    logic             r_acc;
    logic             r_busy;
    logic             r_done;
    logic             r_match;
    logic             w_clr;
    logic             w_en;
    logic             w_last;
    logic [CNT_W-1:0] w_count;

    assign w_clr     = start && (r_state != ST_RUN);
    assign w_en      = (r_state == ST_RUN) && bit_valid;
    assign busy      = r_busy;
    assign done_tick = r_done;
    assign match     = r_match;

    bit_counter #(.N(N)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_acc   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_acc   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bit_valid) begin
                        r_acc <= r_acc & eq_bit;
                        if (w_last) begin
                            r_match <= r_acc & eq_bit;
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_acc   <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EQ_SERIAL_MISMATCH_IDX_EN
    logic             r_mm_seen;
    logic [CNT_W-1:0] r_mm_idx;
    logic [CNT_W-1:0] r_mismatch_idx;

    assign mismatch_idx = r_mismatch_idx;

    // A mismatch on the final bit is never latched in r_mm_idx, so fall back to the live count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mm_seen      <= 1'b0;
            r_mm_idx       <= '0;
            r_mismatch_idx <= '0;
        end else if (w_clr) begin
            r_mm_seen <= 1'b0;
            r_mm_idx  <= '0;
        end else if (w_en) begin
            if (!eq_bit && !r_mm_seen) begin
                r_mm_seen <= 1'b1;
                r_mm_idx  <= w_count;
            end
            if (w_last) begin
                r_mismatch_idx <= (r_acc & eq_bit) ? '0 : (r_mm_seen ? r_mm_idx : w_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_eq_serial_acc.sv
// Directed bench for eq_serial_acc (N=8): idle, full words, gaps, back-to-back,
// ignored start and mid-word reset, with hand-computed expectations.
module tb_eq_serial_acc;
    import eq_pkg::*;

    localparam int N = 8;
    localparam int CNT_W = cnt_w(N);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic eq_bit = 1'b0;
    logic busy;
    logic done_tick;
    logic match;
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
    logic [CNT_W-1:0] mismatch_idx;
`endif

    int checks = 0;
    int errors = 0;

    eq_serial_acc #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bit_valid (bit_valid),
        .eq_bit    (eq_bit),
        .busy      (busy),
        .done_tick (done_tick),
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
        .mismatch_idx (mismatch_idx),
`endif
        .match     (match)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one full word of 8 qualified bits; eq_bit is 0 at index bad (-1 = none).
    // The ignore_at index additionally raises start on that bit.
    task automatic run_word(input string tag, input int bad, input int ignore_at);
        for (int i = 0; i < N; i++) begin
            start     = (i == ignore_at);
            bit_valid = 1'b1;
            eq_bit    = (i != bad);
            step();
            if (i < N - 1) begin
                chk({tag, "_busy_mid"}, busy, 1'b1);
                chk({tag, "_done_early"}, done_tick, 1'b0);
            end
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        eq_bit    = 1'b0;
    endtask

    initial begin
        int q;
        int idle_err;
        int gap;

        // Reset then idle, with bit_valid noise that must be ignored
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done_tick, 1'b0);
        chk("rst_match", match, 1'b0);
        reset_n = 1'b1;
        idle_err = 0;
        for (int i = 0; i < 10; i++) begin
            bit_valid = i[0];
            eq_bit    = i[1];
            step();
            if (busy !== 1'b0 || done_tick !== 1'b0 || match !== 1'b0) idle_err++;
        end
        chk("idle_quiet", idle_err, 0);

        // All-equal word; start with bit_valid in the same cycle (bit with eq=0 not counted)
        start = 1'b1; bit_valid = 1'b1; eq_bit = 1'b0;
        step();
        chk("a_busy_start", busy, 1'b1);
        run_word("a", -1, -1);
        chk("a_done", done_tick, 1'b1);
        chk("a_busy_done", busy, 1'b0);
        chk("a_match", match, 1'b1);
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
        chk("a_idx", mismatch_idx, 0);
`endif
        step();
        chk("a_done_pulse", done_tick, 1'b0);
        chk("a_match_hold", match, 1'b1);
        chk("a_idle_busy", busy, 1'b0);

        // Mismatch at index 5 with bit_valid gaps; invalid cycles carry eq_bit=0 noise
        start = 1'b1;
        step();
        start = 1'b0;
        q = 0;
        for (int c = 0; c < 14 && q < N; c++) begin
            bit_valid = (c % 6 != 1) && (c % 6 != 4);
            eq_bit    = bit_valid ? (q != 5) : 1'b0;
            step();
            if (bit_valid) q++;
            if (q < N) chk("m_done_early", done_tick, 1'b0);
        end
        bit_valid = 1'b0;
        chk("m_qualified", q, N);
        chk("m_done", done_tick, 1'b1);
        chk("m_match", match, 1'b0);
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
        chk("m_idx", mismatch_idx, 5);
`endif
        step();

        // Back-to-back: word A all-equal, start held in DONE, word B mismatch at 0
        start = 1'b1;
        step();
        run_word("bb_a", -1, -1);
        chk("bb_a_done", done_tick, 1'b1);
        chk("bb_a_match", match, 1'b1);
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
        chk("bb_a_idx", mismatch_idx, 0);
`endif
        start = 1'b1;
        step();
        gap = 1;
        chk("bb_rerun_busy", busy, 1'b1);
        chk("bb_match_hold", match, 1'b1);
        run_word("bb_b", 0, -1);
        gap += N;
        chk("bb_b_done", done_tick, 1'b1);
        chk("bb_gap", gap, 9);
        chk("bb_b_match", match, 1'b0);
`ifdef EQ_SERIAL_MISMATCH_IDX_EN
        chk("bb_b_idx", mismatch_idx, 0);
`endif
        step();
        chk("bb_idle", busy, 1'b0);

        // Ignored start at qualified bit 3
        start = 1'b1;
        step();
        run_word("ig", -1, 3);
        chk("ig_done", done_tick, 1'b1);
        chk("ig_match", match, 1'b1);
        step();
        chk("ig_no_restart", busy, 1'b0);

        // Reset mid-word after 4 qualified bits
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; eq_bit = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_match", match, 1'b0);
        idle_err = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 1) reset_n = 1'b1;
            if (done_tick !== 1'b0 || busy !== 1'b0) idle_err++;
        end
        chk("mr_no_done", idle_err, 0);
        start = 1'b1;
        step();
        run_word("mr_full", -1, -1);
        chk("mr_full_done", done_tick, 1'b1);
        chk("mr_full_match", match, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
